// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, FSM encoding and index-width helper for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 32;
  localparam int DMEM_CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Source of data_out while a response is held.
  typedef enum logic [1:0] {
    OUT_ZERO  = 2'd0,
    OUT_RDATA = 2'd1,
    OUT_WDATA = 2'd2
  } out_sel_e;

  function automatic int dmem_iw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word array with registered read data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int  DEPTH = 256,
  localparam int IW    = dmem_iw(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [IW-1:0]      addr_i,
  input  logic [DMEM_DW-1:0] wdata_i,
  output logic [DMEM_DW-1:0] rdata_o
);

  logic [DMEM_DW-1:0] mem_q [DEPTH];
  logic [DMEM_DW-1:0] rdata_q;

  // No reset: contents and last read word survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - request/latency/response FSM in front of dmem_array; DMEM_RANGE_ERR_EN adds resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               rw,
  input  logic [DMEM_AW-1:0] address,
  input  logic [DMEM_DW-1:0] data_in,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DMEM_DW-1:0] data_out,
  output logic               resp_err
);

  localparam int IW = dmem_iw(DEPTH);

  state_e             state_q, state_d;
  logic [DMEM_CW-1:0] cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [DMEM_DW-1:0] wdata_q, wdata_d;
  out_sel_e           sel_q, sel_d;

  logic               in_range;
  logic               access;
  logic               mem_we;
  logic               mem_re;
  logic [DMEM_DW-1:0] mem_rdata;

  assign in_range = {1'b0, addr_q} < (DMEM_AW + 1)'(DEPTH);
  assign access   = (state_q == BUSY) && (cnt_q == '0);
  assign mem_we   = access && rw_q && in_range;
  assign mem_re   = access && !rw_q && in_range;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (clock),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (addr_q[IW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= OUT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rw_d    = rw;
          addr_d  = address;
          wdata_d = data_in;
          cnt_d   = DMEM_CW'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // Out-of-range accesses answer with zero data for both reads and writes.
          if (!in_range) begin
            sel_d = OUT_ZERO;
          end else if (rw_q) begin
            sel_d = OUT_WDATA;
          end else begin
            sel_d = OUT_RDATA;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - DMEM_CW'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    data_out = '0;
    unique case (sel_q)
      OUT_RDATA: data_out = mem_rdata;
      OUT_WDATA: data_out = wdata_q;
      default:   data_out = '0;
    endcase
  end

`ifdef DMEM_RANGE_ERR_EN
  assign resp_err = (state_q == RESP) && !in_range;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench: A = DEPTH 256/LATENCY 2, B = DEPTH 64/LATENCY 0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_req_valid = 1'b0, a_req_ready, a_rw = 1'b0, a_resp_valid, a_resp_ready = 1'b1, a_err;
  logic [7:0]  a_addr = '0;
  logic [31:0] a_din = '0, a_dout;
  logic        b_req_valid = 1'b0, b_req_ready, b_rw = 1'b0, b_resp_valid, b_resp_ready = 1'b1, b_err;
  logic [7:0]  b_addr = '0;
  logic [31:0] b_din = '0, b_dout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

`ifdef DMEM_RANGE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_a (
    .clock(clk), .reset(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .rw(a_rw),
    .address(a_addr), .data_in(a_din), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .data_out(a_dout), .resp_err(a_err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_b (
    .clock(clk), .reset(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .rw(b_rw),
    .address(b_addr), .data_in(b_din), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .data_out(b_dout), .resp_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input bit s);  return s ? b_req_ready  : a_req_ready;  endfunction
  function automatic logic rv(input bit s);   return s ? b_resp_valid : a_resp_valid; endfunction
  function automatic logic rr(input bit s);   return s ? b_resp_ready : a_resp_ready; endfunction
  function automatic logic er(input bit s);   return s ? b_err        : a_err;        endfunction
  function automatic logic [31:0] dout(input bit s); return s ? b_dout : a_dout;      endfunction

  task automatic drive(input bit s, input bit v, input bit w, input logic [7:0] ad, input logic [31:0] d);
    if (s) begin
      b_req_valid = v; b_rw = w; b_addr = ad; b_din = d;
    end else begin
      a_req_valid = v; a_rw = w; a_addr = ad; a_din = d;
    end
  endtask

  // Returns #1 after the edge on which the request was accepted.
  task automatic wait_accept(input bit s, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = rdy(s);
      step();
    end
    chk({tag, "_accept"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_req(input bit s, input bit w, input logic [7:0] ad, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                        input string tag);
    int lat = 0;
    drive(s, 1'b1, w, ad, d);
    wait_accept(s, tag);
    drive(s, 1'b0, w, ad, d);
    chk({tag, "_busy_ready"}, {31'd0, rdy(s)}, 32'd0);
    while (!rv(s) && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, dout(s), exp_data);
    chk({tag, "_err"}, {31'd0, er(s)}, {31'd0, exp_err});
    if (rr(s)) begin
      step();
      chk({tag, "_idle_ready"}, {31'd0, rdy(s)}, 32'd1);
      chk({tag, "_idle_valid"}, {31'd0, rv(s)}, 32'd0);
    end
  endtask

  initial begin
    step();
    step();
    chk("reset_ready", {31'd0, a_req_ready}, 32'd1);
    chk("reset_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("reset_data", a_dout, 32'd0);
    chk("reset_err", {31'd0, a_err}, 32'd0);
    rst = 1'b0;
    step();

    do_req(1'b0, 1'b1, 8'hAA, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0, "t1_wr");
    do_req(1'b0, 1'b0, 8'hAA, 32'h0, 3, 32'hDEADBEEF, 1'b0, "t1_rd");
    do_req(1'b0, 1'b1, 8'h10, 32'h0000_0001, 3, 32'h0000_0001, 1'b0, "t3_pre");

    a_resp_ready = 1'b0;
    do_req(1'b0, 1'b0, 8'hAA, 32'h0, 3, 32'hDEADBEEF, 1'b0, "t2_rd");
    drive(1'b0, 1'b1, 1'b1, 8'hAA, 32'h1111_1111);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", {31'd0, a_resp_valid}, 32'd1);
      chk("t2_hold_data", a_dout, 32'hDEADBEEF);
      chk("t2_hold_ready", {31'd0, a_req_ready}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'hAA, 32'h0);
    a_resp_ready = 1'b1;
    step();
    chk("t2_release_ready", {31'd0, a_req_ready}, 32'd1);
    chk("t2_release_valid", {31'd0, a_resp_valid}, 32'd0);
    do_req(1'b0, 1'b0, 8'hAA, 32'h0, 3, 32'hDEADBEEF, 1'b0, "t2_ignored");

    drive(1'b0, 1'b1, 1'b1, 8'h10, 32'h1234_5678);
    wait_accept(1'b0, "t3_wr");
    drive(1'b0, 1'b0, 1'b0, 8'h10, 32'h0);
    step();
    rst = 1'b1;
    #1;
    chk("t3_rst_ready", {31'd0, a_req_ready}, 32'd1);
    chk("t3_rst_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("t3_rst_data", a_dout, 32'd0);
    repeat (3) step();
    chk("t3_rst_no_resp", {31'd0, a_resp_valid}, 32'd0);
    rst = 1'b0;
    step();
    do_req(1'b0, 1'b0, 8'h10, 32'h0, 3, 32'h0000_0001, 1'b0, "t3_rd");

    do_req(1'b1, 1'b1, 8'h00, 32'h0000_0077, 1, 32'h0000_0077, 1'b0, "t4_w00");
    do_req(1'b1, 1'b1, 8'h40, 32'hFFFFFFFF, 1, 32'h0, ERR_EXP, "t4_w40");
    do_req(1'b1, 1'b0, 8'h40, 32'h0, 1, 32'h0, ERR_EXP, "t4_r40");
    do_req(1'b1, 1'b0, 8'h00, 32'h0, 1, 32'h0000_0077, 1'b0, "t4_r00");
    do_req(1'b1, 1'b1, 8'h3F, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1'b0, "t4_w3f");
    do_req(1'b1, 1'b0, 8'h3F, 32'h0, 1, 32'hA5A5A5A5, 1'b0, "t4_r3f");

    drive(1'b1, 1'b1, 1'b1, 8'h05, 32'hCAFEF00D);
    wait_accept(1'b1, "t5_wr");
    t0 = cyc;
    b_rw = 1'b0;
    step();
    chk("t5_wr_valid", {31'd0, b_resp_valid}, 32'd1);
    chk("t5_wr_data", b_dout, 32'hCAFEF00D);
    wait_accept(1'b1, "t5_rd");
    chk("t5_spacing", cyc - t0, 32'd3);
    drive(1'b1, 1'b0, 1'b0, 8'h05, 32'hCAFEF00D);
    step();
    chk("t5_rd_valid", {31'd0, b_resp_valid}, 32'd1);
    chk("t5_rd_data", b_dout, 32'hCAFEF00D);
    step();
    chk("t5_idle_ready", {31'd0, b_req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
